// File: rtl/uart_telemetry_link.sv
// rtl/uart_telemetry_link.sv - periodic decimal telemetry framer to UART plus LED command parser
module uart_telemetry_link #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 16,
    parameter int DIGITS  = 3,
    parameter int PERIOD  = 1000000,
    parameter int NUM_LED = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic                       force_send,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [NUM_LED-1:0]         led,
    output logic                       frame_sent,
    output logic                       rx_err
);

    localparam int          CNT_W = $clog2(PERIOD);
    localparam int          CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int          K_W   = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam int          BCD_W = 4 * DIGITS;
    localparam int          LEN   = 3 + NUM_CH * DIGITS + (NUM_CH - 1);
    localparam int          IDX_W = $clog2(LEN);
    localparam logic [31:0] MAXV  = 32'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_SNAP, TX_CONV, TX_SEND} tx_state_e;
    typedef enum logic [1:0] {RX_WAIT_L, RX_WAIT_COLON, RX_DIGIT, RX_WAIT_NL} rx_state_e;

    logic [CNT_W-1:0]    cnt_q;
    logic                tick;
    logic                trigger;

    tx_state_e           tx_state_q;
    logic                pending_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic                frame_sent_q;
    logic [IDX_W-1:0]    byte_idx_q;
    logic [CH_W-1:0]     ch_idx_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [DATA_W-1:0]   snap_q   [NUM_CH];
    logic [BCD_W-1:0]    digits_q [NUM_CH];
    logic [DATA_W-1:0]   clamped  [NUM_CH];

    logic [DATA_W-1:0]   bin_src;
    logic [BCD_W-1:0]    bcd_src;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_nxt_d;
    logic [DATA_W-1:0]   bin_nxt_d;
    logic [7:0]          next_byte_d;
    logic [31:0]         nidx;

    rx_state_e           rx_state_q;
    rx_state_e           rx_bad_d;
    logic [K_W-1:0]      rx_k_q;
    logic [NUM_LED-1:0]  shadow_q;
    logic [NUM_LED-1:0]  led_q;
    logic                rx_err_q;

    assign tick       = (cnt_q == CNT_W'(PERIOD - 1));
    assign trigger    = tick || force_send;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign frame_sent = frame_sent_q;
    assign led        = led_q;
    assign rx_err     = rx_err_q;

    // Free-running frame period counter, independent of the transmitter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Saturate each channel to the largest value representable in DIGITS decimal digits
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            clamped[i] = (32'(ch_data[i*DATA_W +: DATA_W]) > MAXV) ? DATA_W'(MAXV)
                                                                   : ch_data[i*DATA_W +: DATA_W];
        end
    end

    // One double-dabble step; the first step of each channel starts from the snapshot
    always_comb begin
        bin_src = (bit_cnt_q == '0) ? snap_q[ch_idx_q] : bin_q;
        bcd_src = (bit_cnt_q == '0) ? '0 : bcd_q;
        bcd_adj = bcd_src;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_src[d*4 +: 4] >= 4'd5) begin
                bcd_adj[d*4 +: 4] = bcd_src[d*4 +: 4] + 4'd3;
            end
        end
        bcd_nxt_d = (bcd_adj << 1) | BCD_W'(bin_src[DATA_W-1]);
        bin_nxt_d = bin_src << 1;
    end

    // Byte that follows the one currently presented on tx_data
    always_comb begin
        nidx        = 32'(byte_idx_q) + 32'd1;
        next_byte_d = 8'h0A;
        if (nidx == 32'd1) begin
            next_byte_d = 8'h3A;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (nidx == 32'(2 + c * (DIGITS + 1) + d)) begin
                    next_byte_d = {4'h3, digits_q[c][(DIGITS-1-d)*4 +: 4]};
                end
            end
            if (c < NUM_CH - 1 && nidx == 32'(2 + c * (DIGITS + 1) + DIGITS)) begin
                next_byte_d = 8'h2C;
            end
        end
    end

    // Transmit FSM: snapshot, convert to BCD, then stream the frame with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q   <= TX_IDLE;
            pending_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            frame_sent_q <= 1'b0;
            byte_idx_q   <= '0;
            ch_idx_q     <= '0;
            bit_cnt_q    <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_q[i]   <= '0;
                digits_q[i] <= '0;
            end
        end else begin
            frame_sent_q <= 1'b0;
            if (trigger && tx_state_q != TX_IDLE) begin
                pending_q <= 1'b1;
            end
            case (tx_state_q)
                TX_IDLE: begin
                    if (trigger || pending_q) begin
                        pending_q  <= 1'b0;
                        tx_state_q <= TX_SNAP;
                    end
                end
                TX_SNAP: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        snap_q[i] <= clamped[i];
                    end
                    ch_idx_q   <= '0;
                    bit_cnt_q  <= '0;
                    tx_state_q <= TX_CONV;
                end
                TX_CONV: begin
                    bin_q     <= bin_nxt_d;
                    bcd_q     <= bcd_nxt_d;
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        digits_q[ch_idx_q] <= bcd_nxt_d;
                        bit_cnt_q          <= '0;
                        if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
                            tx_state_q <= TX_SEND;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= 8'h53;
                            byte_idx_q <= '0;
                        end else begin
                            ch_idx_q <= ch_idx_q + CH_W'(1);
                        end
                    end
                end
                TX_SEND: begin
                    if (tx_ready) begin
                        if (byte_idx_q == IDX_W'(LEN - 1)) begin
                            tx_valid_q   <= 1'b0;
                            frame_sent_q <= 1'b1;
                            tx_state_q   <= TX_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + IDX_W'(1);
                            tx_data_q  <= next_byte_d;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // A stray 'L' restarts a command rather than being lost
    assign rx_bad_d = (rx_data == 8'h4C) ? RX_WAIT_COLON : RX_WAIT_L;

    // Receive FSM: parse "L:<digits>\n" and commit the shadow to led only on a clean frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_WAIT_L;
            rx_k_q     <= '0;
            shadow_q   <= '0;
            led_q      <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_err_q <= 1'b0;
            if (rx_valid) begin
                case (rx_state_q)
                    RX_WAIT_L: begin
                        if (rx_data == 8'h4C) begin
                            rx_state_q <= RX_WAIT_COLON;
                        end
                    end
                    RX_WAIT_COLON: begin
                        if (rx_data == 8'h3A) begin
                            rx_state_q <= RX_DIGIT;
                            rx_k_q     <= '0;
                            shadow_q   <= '0;
                        end else begin
                            rx_err_q   <= 1'b1;
                            rx_state_q <= rx_bad_d;
                        end
                    end
                    RX_DIGIT: begin
                        if (rx_data == 8'h30 || rx_data == 8'h31) begin
                            shadow_q <= shadow_q | (NUM_LED'(rx_data[0]) << rx_k_q);
                            if (rx_k_q == K_W'(NUM_LED - 1)) begin
                                rx_state_q <= RX_WAIT_NL;
                            end else begin
                                rx_k_q <= rx_k_q + K_W'(1);
                            end
                        end else begin
                            rx_err_q   <= 1'b1;
                            rx_state_q <= rx_bad_d;
                        end
                    end
                    RX_WAIT_NL: begin
                        if (rx_data == 8'h0A) begin
                            led_q      <= shadow_q;
                            rx_state_q <= RX_WAIT_L;
                        end else begin
                            rx_err_q   <= 1'b1;
                            rx_state_q <= rx_bad_d;
                        end
                    end
                    default: rx_state_q <= RX_WAIT_L;
                endcase
            end
        end
    end

endmodule
